// File: rtl/systolic_tile_scheduler.sv
// Tiles a blocked matmul onto the 8x8 systolic driver: one driver run per k-tile,
// local accumulation of partial products, then the finished tile streams out row by row.
module systolic_tile_scheduler #(
  parameter int TILE       = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 6
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [2:0]                          m_tiles,
  input  logic [2:0]                          k_tiles,
  input  logic [2:0]                          n_tiles,
  input  logic [ADDR_WIDTH-1:0]               base_A,
  input  logic [ADDR_WIDTH-1:0]               base_B,
  input  logic [ADDR_WIDTH-1:0]               base_C,
  output logic                                drv_start,
  output logic [ADDR_WIDTH-1:0]               drv_base_A,
  output logic [ADDR_WIDTH-1:0]               drv_base_B,
  output logic [DIM_WIDTH-1:0]                drv_dim_A,
  output logic [DIM_WIDTH-1:0]                drv_dim_B,
  input  logic                                drv_done,
  input  logic [TILE*TILE*DATA_WIDTH-1:0]     drv_out,
  output logic                                wr,
  output logic [ADDR_WIDTH-1:0]               wr_addr,
  output logic [TILE*DATA_WIDTH-1:0]          wr_data,
  input  logic                                wr_ready,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [2:0]                          state_dbg
);

  // drv_out element [r][c] lives at bits (r*TILE+c)*DATA_WIDTH; wr_data column c at c*DATA_WIDTH.
  // Write handshake: a row transfers on a posedge where wr && wr_ready; while wr && !wr_ready
  // the scheduler holds wr, wr_addr and wr_data unchanged.
  localparam int ACC_W = TILE * TILE * DATA_WIDTH;
  localparam int ROW_W = TILE * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACCUM = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              mt_q, kt_q, nt_q;
  logic [ADDR_WIDTH-1:0]   ba_q, bb_q, bc_q;
  logic [2:0]              i_q, j_q, k_q, r_q;
  logic                    err_q;
  logic [ACC_W-1:0]        cap_q;
  logic [ACC_W-1:0]        acc_q;

  logic                    dims_zero;
  logic                    last_i, last_j, last_k, last_r;
  logic [5:0]              dim_a, dim_b;
  logic [ADDR_WIDTH-1:0]   addr_a, addr_b, addr_c;

  assign dims_zero = (m_tiles == 3'd0) || (k_tiles == 3'd0) || (n_tiles == 3'd0);
  assign last_i    = (i_q == mt_q - 3'd1);
  assign last_j    = (j_q == nt_q - 3'd1);
  assign last_k    = (k_q == kt_q - 3'd1);
  assign last_r    = (r_q == 3'd7);
  assign dim_a     = {kt_q, 3'b000};
  assign dim_b     = {nt_q, 3'b000};

  // All address arithmetic is carried at ADDR_WIDTH so sums wrap naturally.
  assign addr_a = ba_q + ADDR_WIDTH'({i_q, 3'b000}) * ADDR_WIDTH'(dim_a)
                       + ADDR_WIDTH'({k_q, 3'b000});
  assign addr_b = bb_q + ADDR_WIDTH'({k_q, 3'b000}) * ADDR_WIDTH'(dim_b)
                       + ADDR_WIDTH'({j_q, 3'b000});
  assign addr_c = bc_q + ADDR_WIDTH'({i_q, r_q}) * ADDR_WIDTH'(dim_b)
                       + ADDR_WIDTH'({j_q, 3'b000});

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !dims_zero) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (drv_done) state_d = S_ACCUM;
      S_ACCUM: state_d = last_k ? S_WRITE : S_ISSUE;
      S_WRITE: if (wr_ready && last_r) state_d = (last_i && last_j) ? S_FIN : S_ISSUE;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mt_q    <= '0;
      kt_q    <= '0;
      nt_q    <= '0;
      ba_q    <= '0;
      bb_q    <= '0;
      bc_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      cap_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == S_IDLE) && start && dims_zero;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mt_q <= m_tiles;
            kt_q <= k_tiles;
            nt_q <= n_tiles;
            ba_q <= base_A;
            bb_q <= base_B;
            bc_q <= base_C;
            i_q  <= '0;
            j_q  <= '0;
            k_q  <= '0;
            r_q  <= '0;
          end
        end
        S_WAIT: if (drv_done) cap_q <= drv_out;
        S_ACCUM: begin
          // First k-tile overwrites, later ones add; the adder wraps at DATA_WIDTH.
          for (int e = 0; e < TILE * TILE; e++) begin
            acc_q[e*DATA_WIDTH +: DATA_WIDTH] <= (k_q == 3'd0)
              ? cap_q[e*DATA_WIDTH +: DATA_WIDTH]
              : acc_q[e*DATA_WIDTH +: DATA_WIDTH] + cap_q[e*DATA_WIDTH +: DATA_WIDTH];
          end
          if (!last_k) k_q <= k_q + 3'd1;
          else         r_q <= '0;
        end
        S_WRITE: begin
          if (wr_ready) begin
            if (!last_r) begin
              r_q <= r_q + 3'd1;
            end else begin
              r_q <= '0;
              k_q <= '0;
              if (last_j) begin
                j_q <= '0;
                if (!last_i) i_q <= i_q + 3'd1;
              end else begin
                j_q <= j_q + 3'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign drv_start  = (state_q == S_ISSUE);
  assign drv_base_A = (state_q == S_ISSUE || state_q == S_WAIT) ? addr_a : '0;
  assign drv_base_B = (state_q == S_ISSUE || state_q == S_WAIT) ? addr_b : '0;
  assign drv_dim_A  = DIM_WIDTH'(dim_a);
  assign drv_dim_B  = DIM_WIDTH'(dim_b);
  assign wr         = (state_q == S_WRITE);
  assign wr_addr    = (state_q == S_WRITE) ? addr_c : '0;
  assign wr_data    = (state_q == S_WRITE) ? acc_q[r_q*ROW_W +: ROW_W] : '0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed bench for systolic_tile_scheduler: a tile-level matmul model predicts every
// driver request and row write; a per-cycle compare checks the DUT against it.
module tb_systolic_tile_scheduler;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int T  = 8;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               start;
  logic [2:0]         m_tiles, k_tiles, n_tiles;
  logic [AW-1:0]      base_A, base_B, base_C;
  logic               drv_start;
  logic [AW-1:0]      drv_base_A, drv_base_B;
  logic [5:0]         drv_dim_A, drv_dim_B;
  logic               drv_done;
  logic [T*T*DW-1:0]  drv_out;
  logic               wr;
  logic [AW-1:0]      wr_addr;
  logic [T*DW-1:0]    wr_data;
  logic               wr_ready;
  logic               busy, done, err;
  logic [2:0]         state_dbg;

  always #5 clock = ~clock;

  systolic_tile_scheduler dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .m_tiles(m_tiles), .k_tiles(k_tiles), .n_tiles(n_tiles),
    .base_A(base_A), .base_B(base_B), .base_C(base_C),
    .drv_start(drv_start), .drv_base_A(drv_base_A), .drv_base_B(drv_base_B),
    .drv_dim_A(drv_dim_A), .drv_dim_B(drv_dim_B),
    .drv_done(drv_done), .drv_out(drv_out),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [2*AW-1:0]  exp_drv_q[$];
  logic [AW-1:0]    exp_wr_addr_q[$];
  logic [T*DW-1:0]  exp_wr_data_q[$];
  logic [2*AW-1:0]  seen_drv[$];
  logic [AW-1:0]    seen_addr[$];
  logic [T*DW-1:0]  seen_data[$];
  logic [5:0]       exp_dim_a, exp_dim_b;
  int               done_cnt = 0;
  int               err_cnt = 0;
  bit               idle_expect = 0;
  bit               stalled_prev = 0;
  logic [AW-1:0]    prev_addr;
  logic [T*DW-1:0]  prev_data;

  int run_cnt = 0;
  bit pend = 0;
  int cd = 0;
  int pend_run = 0;
  int lat = 5;
  int stall = 0;
  int md = 0;
  int stall_cnt = 0;

  task automatic check(input string name, input logic [T*DW-1:0] act, input logic [T*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Driver result patterns, indexed by global run number.
  function automatic logic [DW-1:0] resp(input int mode, input int run, input int r, input int c);
    case (mode)
      0:       return DW'(r * 8 + c);
      1:       return DW'(run % 3 + 1);
      2:       return DW'(run * 1000 + r * 37 + c * 5);
      default: return 32'hFFFF_FFF0 + DW'(run + r * 8 + c);
    endcase
  endfunction

  task automatic compare_outputs();
    logic [2*AW-1:0] e;
    if (drv_start) begin
      seen_drv.push_back({drv_base_A, drv_base_B});
      check("busy during drv_start", busy, 1);
      if (exp_drv_q.size() == 0) begin
        fail_now($sformatf("unexpected drv_start: base_A %0d base_B %0d, none required", drv_base_A, drv_base_B));
      end else begin
        e = exp_drv_q.pop_front();
        check("drv_base_A", drv_base_A, e[2*AW-1:AW]);
        check("drv_base_B", drv_base_B, e[AW-1:0]);
        check("drv_dim_A", drv_dim_A, exp_dim_a);
        check("drv_dim_B", drv_dim_B, exp_dim_b);
      end
    end
    if (wr) begin
      if (stalled_prev) begin
        check("wr_addr hold", wr_addr, prev_addr);
        check("wr_data hold", wr_data, prev_data);
      end
      if (wr_ready) begin
        stalled_prev = 0;
        seen_addr.push_back(wr_addr);
        seen_data.push_back(wr_data);
        if (exp_wr_addr_q.size() == 0) begin
          fail_now($sformatf("unexpected write: addr %0d, none required", wr_addr));
        end else begin
          check("wr_addr", wr_addr, exp_wr_addr_q.pop_front());
          check("wr_data", wr_data, exp_wr_data_q.pop_front());
        end
      end else begin
        stalled_prev = 1;
        prev_addr = wr_addr;
        prev_data = wr_data;
      end
    end else begin
      stalled_prev = 0;
    end
    if (done) begin
      done_cnt++;
      check("writes outstanding at done", exp_wr_addr_q.size(), 0);
    end
    if (err) err_cnt++;
    if (idle_expect) check("busy while idle", busy, 0);
  endtask

  task automatic drive_responder();
    drv_done = 1'b0;
    if (pend) begin
      if (cd <= 0) begin
        drv_done = 1'b1;
        for (int r = 0; r < T; r++)
          for (int c = 0; c < T; c++)
            drv_out[(r*T+c)*DW +: DW] = resp(md, pend_run, r, c);
        pend = 0;
      end else begin
        cd--;
      end
    end
    if (drv_start) begin
      pend = 1;
      cd = lat;
      pend_run = run_cnt;
      run_cnt++;
    end
    if (stall == 0) begin
      wr_ready = 1'b1;
    end else if (wr && stall_cnt < stall) begin
      wr_ready = 1'b0;
      stall_cnt++;
    end else if (wr) begin
      wr_ready = 1'b1;
      stall_cnt = 0;
    end else begin
      wr_ready = 1'b0;
      stall_cnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    compare_outputs();
    @(posedge clock);
    #1;
    drive_responder();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {drv_start, drv_base_A, drv_base_B, drv_dim_A, drv_dim_B, wr, wr_addr,
                 busy, done, err}, 0);
    check({name, " wr_data"}, wr_data, 0);
  endtask

  // Predicts the whole job: driver requests in (i, j, k) order and 8 row writes per tile.
  task automatic build_job(input int m, input int k, input int n, input int ba, input int bb,
                           input int bc, input int mode);
    logic [DW-1:0]   acc[T*T];
    logic [T*DW-1:0] row;
    int              run;
    exp_dim_a = 6'(8 * k);
    exp_dim_b = 6'(8 * n);
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        for (int e = 0; e < T*T; e++) acc[e] = '0;
        for (int kk = 0; kk < k; kk++) begin
          run = run_cnt + (i * n + j) * k + kk;
          exp_drv_q.push_back({AW'(ba + 64 * i * k + 8 * kk), AW'(bb + 64 * kk * n + 8 * j)});
          for (int e = 0; e < T*T; e++) acc[e] = acc[e] + resp(mode, run, e / T, e % T);
        end
        for (int r = 0; r < T; r++) begin
          for (int c = 0; c < T; c++) row[c*DW +: DW] = acc[r*T+c];
          exp_wr_addr_q.push_back(AW'(bc + (8 * i + r) * 8 * n + 8 * j));
          exp_wr_data_q.push_back(row);
        end
      end
    end
  endtask

  task automatic launch_job(input int m, input int k, input int n, input int ba, input int bb,
                            input int bc, input int mode, input int l, input int st);
    lat = l;
    stall = st;
    md = mode;
    seen_drv.delete();
    seen_addr.delete();
    seen_data.delete();
    done_cnt = 0;
    build_job(m, k, n, ba, bb, bc, mode);
    m_tiles = 3'(m);
    k_tiles = 3'(k);
    n_tiles = 3'(n);
    base_A = AW'(ba);
    base_B = AW'(bb);
    base_C = AW'(bc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_job(input int budget);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin
      tick();
      t++;
    end
    if (done_cnt == 0) fail_now("timeout waiting for done");
    idle_expect = 1;
    tick();
    tick();
    idle_expect = 0;
    check("done pulse count", done_cnt, 1);
    check("driver runs outstanding", exp_drv_q.size(), 0);
    check("writes outstanding", exp_wr_addr_q.size(), 0);
  endtask

  initial begin
    int t;
    reset_n = 1'b0;
    start = 1'b0;
    m_tiles = '0;
    k_tiles = '0;
    n_tiles = '0;
    base_A = '0;
    base_B = '0;
    base_C = '0;
    drv_done = 1'b0;
    drv_out = '0;
    wr_ready = 1'b1;
    @(posedge clock);
    #1;
    tick();
    tick();
    check_all_zero("reset outputs");
    check("reset state", state_dbg, 0);
    reset_n = 1'b1;
    tick();

    // 1x1x1: single driver run, result copied straight out.
    launch_job(1, 1, 1, 0, 64, 128, 0, 5, 0);
    finish_job(200);
    check("t1 driver runs", seen_drv.size(), 1);
    check("t1 writes", seen_addr.size(), 8);
    if (seen_addr.size() == 8) begin
      check("t1 drv bases", seen_drv[0], {12'd0, 12'd64});
      check("t1 last addr", seen_addr[7], 184);
      check("t1 row2 col5", seen_data[2][5*DW +: DW], 21);
    end

    // 1x3x1: three k-runs of 1,2,3 (in some rotation) accumulate to 6.
    launch_job(1, 3, 1, 0, 64, 128, 1, 3, 0);
    finish_job(300);
    check("t2 driver runs", seen_drv.size(), 3);
    if (seen_drv.size() == 3 && seen_data.size() == 8) begin
      check("t2 run1 bases", seen_drv[1], {12'd8, 12'd128});
      check("t2 run2 bases", seen_drv[2], {12'd16, 12'd192});
      check("t2 sum", seen_data[4][3*DW +: DW], 6);
    end

    // 2x1x2: tile order and C addressing across tiles.
    launch_job(2, 1, 2, 0, 64, 100, 2, 2, 0);
    finish_job(400);
    check("t3 writes", seen_addr.size(), 32);
    if (seen_addr.size() == 32 && seen_drv.size() == 4) begin
      check("t3 tile01 addr", seen_addr[8], 108);
      check("t3 tile10 addr", seen_addr[16], 228);
      check("t3 tile11 row7", seen_addr[31], 348);
      check("t3 tile10 bases", seen_drv[2], {12'd64, 12'd64});
    end

    // Write back-pressure and zero driver latency.
    launch_job(1, 2, 1, 40, 200, 300, 2, 0, 3);
    finish_job(400);
    check("t4 writes", seen_addr.size(), 8);

    // Address and data wraparound.
    launch_job(1, 2, 2, 12'hFF8, 12'hFC0, 12'hFF0, 3, 3, 0);
    finish_job(400);

    // Zero dimension: err only.
    stall = 0;
    err_cnt = 0;
    seen_drv.delete();
    m_tiles = 3'd1;
    k_tiles = 3'd0;
    n_tiles = 3'd1;
    start = 1'b1;
    idle_expect = 1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    m_tiles = 3'd0;
    k_tiles = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    idle_expect = 0;
    check("err pulses", err_cnt, 2);
    check("err no driver runs", seen_drv.size(), 0);

    // start while busy is ignored.
    launch_job(1, 1, 1, 16, 32, 48, 2, 8, 0);
    tick();
    tick();
    m_tiles = 3'd2;
    k_tiles = 3'd2;
    n_tiles = 3'd2;
    base_A = 12'd500;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_job(200);

    // Reset while waiting on the driver; its late done must be ignored.
    launch_job(1, 1, 1, 0, 64, 128, 0, 15, 0);
    t = 0;
    while (seen_drv.size() == 0 && t < 20) begin
      tick();
      t++;
    end
    if (seen_drv.size() == 0) fail_now("timeout waiting for drv_start before reset");
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check_all_zero("mid-job reset outputs");
    tick();
    reset_n = 1'b1;
    exp_drv_q.delete();
    exp_wr_addr_q.delete();
    exp_wr_data_q.delete();
    seen_addr.delete();
    idle_expect = 1;
    for (int c = 0; c < 20; c++) tick();
    idle_expect = 0;
    check("no writes after abort", seen_addr.size(), 0);
    check("no done after abort", done_cnt, 0);
    check("abort driver released", pend, 0);

    launch_job(1, 1, 1, 8, 72, 136, 2, 4, 0);
    finish_job(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
